// File: rtl/button_events.sv
// Push-button front end: 2-flop sync, per-bit debounce, single-button decode, press/auto-repeat event FSM.
// Latency: raw edge stable after edge 0 -> db at edge DEBOUNCE_CYCLES+2 -> event/held registered at edge DEBOUNCE_CYCLES+3.
// Backpressure: none; events are one-cycle pulses and must be consumed when they occur.
//
// Ports:
//   clk, rst       system clock (rising edge), asynchronous active-high reset
//   buttons        raw asynchronous button levels, 1 = pressed
//   button_pushed  one-cycle event pulse (press or auto-repeat)
//   button_repeat  high together with button_pushed when the event is an auto-repeat
//   button_state   code of the last single held button (bit i -> NUM_BUTTONS-1-i), sticky
//   button_held    level: exactly one debounced button is pressed
module button_events #(
    parameter int NUM_BUTTONS     = 4,
    parameter int IDX_W           = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic                   button_pushed,
    output logic                   button_repeat,
    output logic [IDX_W-1:0]       button_state,
    output logic                   button_held
);

    localparam int CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RPT_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_PER   = RW'(REPEAT_PERIOD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_DELAY,
        ST_REPEAT
    } state_t;

    // State entered on every fresh press: DELAY when auto-repeat is enabled.
    localparam state_t PRESS_ST = (REPEAT_DELAY > 0) ? ST_DELAY : ST_HOLD;

    // ------------------------------------------------------------------
    // Synchroniser and debounce
    // ------------------------------------------------------------------
    logic [NUM_BUTTONS-1:0]         r1_q, r1_d;
    logic [NUM_BUTTONS-1:0]         sync_q, sync_d;
    logic [NUM_BUTTONS-1:0]         db_q, db_d;
    logic [NUM_BUTTONS-1:0][CW-1:0] db_cnt_q, db_cnt_d;

    always_comb begin
        r1_d     = buttons;
        sync_d   = r1_q;
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (sync_q[i] == db_q[i]) begin
                // Any return to the accepted level restarts the qualification window.
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_d[i]     = sync_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_q     <= '0;
            sync_q   <= '0;
            db_q     <= '0;
            db_cnt_q <= '0;
        end else begin
            r1_q     <= r1_d;
            sync_q   <= sync_d;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Single-button decode
    // ------------------------------------------------------------------
    logic             single;
    logic [IDX_W-1:0] code;

    always_comb begin
        single = 1'b0;
        code   = '0;
        // One-hot test: non-zero with no second set bit.
        if ((db_q != '0) && ((db_q & (db_q - NUM_BUTTONS'(1))) == '0)) begin
            single = 1'b1;
        end
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (db_q[i]) begin
                code = IDX_W'(NUM_BUTTONS - 1 - i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FSM and registered outputs
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [RW-1:0]    rpt_cnt_q, rpt_cnt_d;
    logic             pushed_q, pushed_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;
    logic [IDX_W-1:0] btn_state_q, btn_state_d;
    logic             code_chg;

    // btn_state_q always tracks the code of the button currently being serviced.
    assign code_chg = (code != btn_state_q);

    always_comb begin
        state_d     = state_q;
        rpt_cnt_d   = rpt_cnt_q;
        pushed_d    = 1'b0;
        repeat_d    = 1'b0;
        held_d      = single;
        btn_state_d = single ? code : btn_state_q;

        case (state_q)
            ST_IDLE: begin
                if (single) begin
                    pushed_d  = 1'b1;
                    rpt_cnt_d = RW'(1);
                    state_d   = PRESS_ST;
                end
            end
            ST_HOLD: begin
                if (!single) begin
                    state_d = ST_IDLE;
                end else if (code_chg) begin
                    pushed_d  = 1'b1;
                    rpt_cnt_d = RW'(1);
                    state_d   = PRESS_ST;
                end
            end
            ST_DELAY: begin
                if (!single) begin
                    state_d = ST_IDLE;
                end else if (code_chg) begin
                    pushed_d  = 1'b1;
                    rpt_cnt_d = RW'(1);
                    state_d   = ST_DELAY;
                end else if (rpt_cnt_q == RPT_DELAY) begin
                    pushed_d  = 1'b1;
                    repeat_d  = 1'b1;
                    rpt_cnt_d = RW'(1);
                    state_d   = ST_REPEAT;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RW'(1);
                end
            end
            ST_REPEAT: begin
                if (!single) begin
                    state_d = ST_IDLE;
                end else if (code_chg) begin
                    pushed_d  = 1'b1;
                    rpt_cnt_d = RW'(1);
                    state_d   = ST_DELAY;
                end else if (rpt_cnt_q == RPT_PER) begin
                    pushed_d  = 1'b1;
                    repeat_d  = 1'b1;
                    rpt_cnt_d = RW'(1);
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rpt_cnt_q   <= '0;
            pushed_q    <= 1'b0;
            repeat_q    <= 1'b0;
            held_q      <= 1'b0;
            btn_state_q <= '0;
        end else begin
            state_q     <= state_d;
            rpt_cnt_q   <= rpt_cnt_d;
            pushed_q    <= pushed_d;
            repeat_q    <= repeat_d;
            held_q      <= held_d;
            btn_state_q <= btn_state_d;
        end
    end

    assign button_pushed = pushed_q;
    assign button_repeat = repeat_q;
    assign button_held   = held_q;
    assign button_state  = btn_state_q;

endmodule

// File: tb/tb_button_events.sv
// Testbench for button_events: table of level/duration rows with expected event counts,
// plus hand-written sequences for exact latency, reset mid-operation and repeat-disabled config.
module tb_button_events;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] buttons;
    logic       button_pushed;
    logic       button_repeat;
    logic [1:0] button_state;
    logic       button_held;

    logic [3:0] buttons_b;
    logic       pushed_b;
    logic       repeat_b;
    logic [1:0] state_b;
    logic       held_b;

    always #5 clk = ~clk;

    button_events #(
        .NUM_BUTTONS(4), .IDX_W(2), .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .rst(rst), .buttons(buttons),
        .button_pushed(button_pushed), .button_repeat(button_repeat),
        .button_state(button_state), .button_held(button_held)
    );

    button_events #(
        .NUM_BUTTONS(4), .IDX_W(2), .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(0), .REPEAT_PERIOD(1)
    ) dut_norpt (
        .clk(clk), .rst(rst), .buttons(buttons_b),
        .button_pushed(pushed_b), .button_repeat(repeat_b),
        .button_state(state_b), .button_held(held_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Sample point: 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n edges on the main instance, counting press events and repeat events.
    task automatic run_count(input int n, output int presses, output int repeats);
        presses = 0;
        repeats = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (button_pushed && !button_repeat) presses++;
            if (button_repeat) repeats++;
        end
    endtask

    typedef struct {
        logic [3:0] btn;
        int         cycles;
        int         presses;
        int         repeats;
        int         state;
        int         held;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int np, nr;

        // Rows continue from one another; each applies a level for a number of edges.
        vecs[0]  = '{4'b0000, 12, 0, 0, 0, 0};  // idle
        vecs[1]  = '{4'b0001, 30, 1, 5, 3, 1};  // press @7, repeats @17,20,23,26,29
        vecs[2]  = '{4'b0000, 12, 0, 2, 3, 0};  // repeats @2,5 before release is debounced
        vecs[3]  = '{4'b0100,  3, 0, 0, 3, 0};  // 3-cycle glitch
        vecs[4]  = '{4'b0000, 12, 0, 0, 3, 0};  // glitch never accepted
        vecs[5]  = '{4'b0100,  4, 0, 0, 3, 0};  // 4-cycle pulse, not yet visible
        vecs[6]  = '{4'b0000, 14, 1, 0, 1, 0};  // ...pulse accepted: press, then released
        vecs[7]  = '{4'b0100,  8, 1, 0, 1, 1};  // press bit 2
        vecs[8]  = '{4'b0110, 12, 0, 0, 1, 0};  // add bit 1: held drops, no event
        vecs[9]  = '{4'b0010, 10, 1, 0, 2, 1};  // release bit 2: fresh press of bit 1
        vecs[10] = '{4'b0000, 12, 0, 0, 2, 0};  // release before first repeat
        vecs[11] = '{4'b1000, 10, 1, 0, 0, 1};  // press bit 3
        vecs[12] = '{4'b0100, 10, 1, 0, 1, 1};  // direct code change = new press
        vecs[13] = '{4'b0000, 12, 0, 0, 1, 0};  // release

        rst       = 1'b1;
        buttons   = 4'b0000;
        buttons_b = 4'b0000;
        repeat (3) tick();

        // Reset state
        check("rst_pushed", int'(button_pushed), 0);
        check("rst_repeat", int'(button_repeat), 0);
        check("rst_held",   int'(button_held),   0);
        check("rst_state",  int'(button_state),  0);
        check("rst_b_held", int'(held_b),        0);

        // Exact latency: raw level applied right after edge 0.
        rst     = 1'b0;
        buttons = 4'b1000;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("lat_pushed_e%0d", k), int'(button_pushed), (k == 7) ? 1 : 0);
            check($sformatf("lat_repeat_e%0d", k), int'(button_repeat), 0);
            check($sformatf("lat_held_e%0d", k),   int'(button_held),   (k >= 7) ? 1 : 0);
        end
        check("lat_state", int'(button_state), 0);
        buttons = 4'b0000;
        repeat (20) tick();

        // Table-driven rows
        for (int v = 0; v < 14; v++) begin
            buttons = vecs[v].btn;
            run_count(vecs[v].cycles, np, nr);
            check($sformatf("row%0d_presses", v), np, vecs[v].presses);
            check($sformatf("row%0d_repeats", v), nr, vecs[v].repeats);
            check($sformatf("row%0d_state", v),   int'(button_state), vecs[v].state);
            check($sformatf("row%0d_held", v),    int'(button_held),  vecs[v].held);
        end

        // Reset while in DELAY with a button held
        buttons = 4'b0001;
        run_count(10, np, nr);
        check("mid_press", np, 1);
        check("mid_state_before_rst", int'(button_state), 3);
        check("mid_held_before_rst",  int'(button_held),  1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pushed", int'(button_pushed), 0);
        check("arst_repeat", int'(button_repeat), 0);
        check("arst_held",   int'(button_held),   0);
        check("arst_state",  int'(button_state),  0);
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("post_rst_pushed_e%0d", k), int'(button_pushed), (k == 7) ? 1 : 0);
        end
        check("post_rst_state", int'(button_state), 3);
        check("post_rst_held",  int'(button_held),  1);
        buttons = 4'b0000;

        // Auto-repeat disabled instance: one press, never a repeat
        buttons_b = 4'b0010;
        np = 0;
        nr = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (pushed_b) np++;
            if (repeat_b) nr++;
        end
        check("norpt_pushes",  np, 1);
        check("norpt_repeats", nr, 0);
        check("norpt_state",   int'(state_b), 2);
        check("norpt_held",    int'(held_b),  1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
